// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU operation codes, RV32M funct3
// values, forward-select codes and the mul/div sequencer states.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_ZERO = 4'd10
    } alu_op_t;

    // RV32M funct3; bit 2 separates divide from multiply, bit 1 picks REM.
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_stage_if.sv
// EX stage pipeline bus: operands and controls in, result and stall out.
interface ex_muldiv_stage_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         flush;
    logic         is_muldiv;
    logic [2:0]   md_op;
    logic [3:0]   alu_op;
    logic         ALUSrc;
    logic [W-1:0] regReadData1;
    logic [W-1:0] regReadData2;
    logic [W-1:0] imm;
    logic [W-1:0] fd_ex_mem_data;
    logic [W-1:0] fd_mem_wb_data;
    logic [1:0]   forwardA;
    logic [1:0]   forwardB;
    logic         stall;
    logic         out_valid;
    logic [W-1:0] ALUresult;
    logic [W-1:0] data2;
    logic         zero;

    // EX stage side
    modport slave (
        input  in_valid, flush, is_muldiv, md_op, alu_op, ALUSrc,
               regReadData1, regReadData2, imm, fd_ex_mem_data, fd_mem_wb_data,
               forwardA, forwardB,
        output stall, out_valid, ALUresult, data2, zero
    );

    // Pipeline / driver side
    modport master (
        output in_valid, flush, is_muldiv, md_op, alu_op, ALUSrc,
               regReadData1, regReadData2, imm, fd_ex_mem_data, fd_mem_wb_data,
               forwardA, forwardB,
        input  stall, out_valid, ALUresult, data2, zero
    );
endinterface

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// Iterative RV32M datapath: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, W steps, sign fix-up on the final step.
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = $clog2(W) + 1;

    // prod_reg: multiply {partial hi, multiplier lo}; divide {remainder, dividend/quotient}
    logic [2*W-1:0] prod_reg, prod_next, prod_fix;
    logic [W-1:0]   opnd_reg;
    logic [W-1:0]   result_reg, result_next;
    logic [CW-1:0]  count_reg;
    logic [2:0]     op_reg;
    logic           a_neg_reg, b_neg_reg, b_zero_reg;

    logic           a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [W-1:0]   quo, rem, quo_fix, rem_fix;

    // Operand signedness and magnitudes at acceptance
    always_comb begin
        a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        a_neg    = a_signed & a[W-1];
        b_neg    = b_signed & b[W-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
    end

    // One iteration step plus the sign-corrected result it would finish with
    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*W-1:W]} + (prod_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {prod_reg[2*W-1:W], prod_reg[W-1]};
        div_ge    = div_shift >= {1'b0, opnd_reg};
        // Any accepted difference is below the divisor, so W bits hold it
        div_diff  = div_shift[W-1:0] - opnd_reg;
        if (op_reg[2]) begin
            prod_next = div_ge ? {div_diff, prod_reg[W-2:0], 1'b1}
                               : {div_shift[W-1:0], prod_reg[W-2:0], 1'b0};
        end else begin
            prod_next = {mul_sum, prod_reg[W-1:1]};
        end
        prod_fix = (a_neg_reg ^ b_neg_reg) ? -prod_next : prod_next;
        quo      = prod_next[W-1:0];
        rem      = prod_next[2*W-1:W];
        // Divide by zero keeps the all-ones quotient regardless of dividend sign
        quo_fix  = ((a_neg_reg ^ b_neg_reg) & ~b_zero_reg) ? -quo : quo;
        rem_fix  = a_neg_reg ? -rem : rem;
        if (op_reg[2]) begin
            result_next = op_reg[1] ? rem_fix : quo_fix;
        end else begin
            result_next = (op_reg == MD_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end
    end

    // Operand latch on start, one step per busy cycle, result captured on the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg   <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            op_reg     <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
        end else if (start) begin
            prod_reg   <= {{W{1'b0}}, (op[2] ? mag_a : mag_b)};
            opnd_reg   <= op[2] ? mag_b : mag_a;
            count_reg  <= CW'(W);
            op_reg     <= op;
            a_neg_reg  <= a_neg;
            b_neg_reg  <= b_neg;
            b_zero_reg <= (b == '0);
        end else if (step) begin
            prod_reg  <= prod_next;
            count_reg <= count_reg - 1'b1;
            if (count_reg == CW'(1)) begin
                result_reg <= result_next;
            end
        end
    end

    assign done   = step && (count_reg == CW'(1));
    assign result = result_reg;

endmodule

// File: rtl/ex_muldiv_stage.sv
// EX stage: operand forwarding, single-cycle ALU, and a stalling
// IDLE/BUSY/DONE sequencer around the iterative mul/div unit.
module ex_muldiv_stage
    import ex_pkg::*;
#(
    parameter int                       WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] FWD_POISON    = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_muldiv_stage_if.slave bus
);
    localparam int W   = WORD_BITWIDTH;
    localparam int SHW = $clog2(W);

    logic [W-1:0] fwd_src_reg [2];
    logic [1:0]   fwd_sel     [2];
    logic [W-1:0] fwd_val     [2];
    logic [W-1:0] op_a, op_b, alu_res, stage_result, md_result;
    md_state_t    state_reg, state_next;
    logic         md_start, md_step, md_done, stall_raw, valid_raw;

    assign fwd_src_reg[0] = bus.regReadData1;
    assign fwd_src_reg[1] = bus.regReadData2;
    assign fwd_sel[0]     = bus.forwardA;
    assign fwd_sel[1]     = bus.forwardB;

    // Same forward mux for both operands; the unused code yields a recognisable poison value
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_val[gi] = (fwd_sel[gi] == FWD_REG)    ? fwd_src_reg[gi]    :
                             (fwd_sel[gi] == FWD_EX_MEM) ? bus.fd_ex_mem_data :
                             (fwd_sel[gi] == FWD_MEM_WB) ? bus.fd_mem_wb_data :
                                                           FWD_POISON;
    end

    assign op_a      = fwd_val[0];
    assign op_b      = bus.ALUSrc ? bus.imm : fwd_val[1];
    assign bus.data2 = fwd_val[1];

    // Single-cycle ALU
    always_comb begin
        alu_res = '0;
        case (alu_op_t'(bus.alu_op))
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << op_b[SHW-1:0];
            ALU_SRL:  alu_res = op_a >> op_b[SHW-1:0];
            ALU_SRA:  alu_res = $signed(op_a) >>> op_b[SHW-1:0];
            ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
            ALU_ZERO: alu_res = '0;
            default:  alu_res = '0;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sequencer next state, stall and valid
    always_comb begin
        state_next = state_reg;
        md_start   = 1'b0;
        stall_raw  = 1'b0;
        valid_raw  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    if (bus.is_muldiv) begin
                        md_start   = 1'b1;
                        stall_raw  = 1'b1;
                        state_next = ST_BUSY;
                    end else begin
                        valid_raw = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else begin
                    stall_raw = 1'b1;
                    if (md_done) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                valid_raw  = !bus.flush;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign md_step = (state_reg == ST_BUSY);

    muldiv_iter #(
        .W(W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .step   (md_step),
        .op     (bus.md_op),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );

    // Reset must silence the handshake at once, even while a mul/div is presented
    assign bus.stall     = stall_raw & rst_n;
    assign bus.out_valid = valid_raw & rst_n;

    assign stage_result  = (state_reg == ST_DONE) ? md_result : alu_res;
    assign bus.ALUresult = stage_result;
    assign bus.zero      = (stage_result == '0);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: directed and randomized ALU / mul / div
// traffic against a plain-arithmetic reference model.
module tb_ex_muldiv_stage;
    import ex_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_stage_if #(.W(W)) bus ();

    ex_muldiv_stage #(
        .WORD_BITWIDTH (W),
        .FWD_POISON    (32'hDEADBEEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (alu_op_t'(op))
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << (b % 32);
            ALU_SRL:  return a >> (b % 32);
            ALU_SRA:  return $signed(a) >>> (b % 32);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        case (op)
            MD_MUL:    begin p = 64'(ua * ub); r = p[31:0];  end
            MD_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
            MD_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
            MD_MULHU:  begin p = 64'(ua * ub); r = p[63:32]; end
            MD_DIV:    begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            MD_REM:    begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            MD_DIVU:   begin
                if (b == 0) r = 32'hFFFFFFFF;
                else begin p = 64'(ua / ub); r = p[31:0]; end
            end
            default:   begin
                if (b == 0) r = a;
                else begin p = 64'(ua % ub); r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sel_code(input int s);
        case (s)
            0:       return 2'b00;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic drive_idle();
        bus.in_valid       = 1'b0;
        bus.flush          = 1'b0;
        bus.is_muldiv      = 1'b0;
        bus.md_op          = 3'd0;
        bus.alu_op         = 4'd0;
        bus.ALUSrc         = 1'b0;
        bus.regReadData1   = '0;
        bus.regReadData2   = '0;
        bus.imm            = '0;
        bus.fd_ex_mem_data = '0;
        bus.fd_mem_wb_data = '0;
        bus.forwardA       = 2'b00;
        bus.forwardB       = 2'b00;
    endtask

    // Route a and b through randomly chosen forward paths; returns the forwarded B value
    task automatic set_operands(input logic [31:0] a, input logic [31:0] b, input bit use_imm,
                                output logic [31:0] fwd_b);
        int fa = $urandom_range(0, 2);
        int fb = $urandom_range(0, 2);
        if (fa == fb && fa != 0) fb = 0;
        bus.regReadData1   = $urandom;
        bus.regReadData2   = $urandom;
        bus.fd_ex_mem_data = $urandom;
        bus.fd_mem_wb_data = $urandom;
        fwd_b = use_imm ? 32'($urandom) : b;
        case (fa)
            0:       bus.regReadData1   = a;
            1:       bus.fd_ex_mem_data = a;
            default: bus.fd_mem_wb_data = a;
        endcase
        case (fb)
            0:       bus.regReadData2   = fwd_b;
            1:       bus.fd_ex_mem_data = fwd_b;
            default: bus.fd_mem_wb_data = fwd_b;
        endcase
        bus.imm      = use_imm ? b : 32'($urandom);
        bus.ALUSrc   = use_imm;
        bus.forwardA = sel_code(fa);
        bus.forwardB = sel_code(fb);
    endtask

    // Drive one ALU op for one cycle; called and returning at posedge+1
    task automatic run_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit use_imm, input string name);
        logic [31:0] fb;
        logic [31:0] exp;
        set_operands(a, b, use_imm, fb);
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b0;
        bus.flush     = 1'b0;
        bus.alu_op    = op;
        exp = ref_alu(op, a, b);
        @(negedge clk);
        checks++;
        if (bus.ALUresult !== exp || bus.out_valid !== 1'b1 || bus.stall !== 1'b0 ||
            bus.zero !== (exp == 0) || bus.data2 !== fb) begin
            errors++;
            $display("FAIL %s op=%0d a=%h b=%h: got res=%h valid=%b stall=%b zero=%b data2=%h, want res=%h valid=1 stall=0 zero=%b data2=%h",
                     name, op, a, b, bus.ALUresult, bus.out_valid, bus.stall, bus.zero, bus.data2,
                     exp, (exp == 0), fb);
        end
        $display("alu %s op=%0d a=%h b=%h imm=%0d res=%h", name, op, a, b, use_imm, bus.ALUresult);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Issue one mul/div and follow it to completion, checking latency and stall length
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        logic [31:0] fb;
        int          stall_cnt;
        int          lat;
        bit          seen;
        set_operands(a, b, 1'b0, fb);
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.flush     = 1'b0;
        bus.md_op     = op;
        bus.alu_op    = 4'($urandom_range(0, 10));
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: got stall=%b valid=%b, want stall=1 valid=0", name, bus.stall, bus.out_valid);
        end
        stall_cnt = 1;
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(posedge clk); #1;
            bus.regReadData1   = $urandom;
            bus.regReadData2   = $urandom;
            bus.fd_ex_mem_data = $urandom;
            bus.fd_mem_wb_data = $urandom;
            @(negedge clk);
            if (bus.stall === 1'b1) stall_cnt++;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                lat = k;
            end
        end
        checks++;
        if (!seen || lat != W + 1 || stall_cnt != W + 1 || bus.stall !== 1'b0 ||
            bus.ALUresult !== exp || bus.zero !== (exp == 0)) begin
            errors++;
            $display("FAIL %s op=%0d a=%h b=%h: got seen=%0d lat=%0d stall_cycles=%0d res=%h zero=%b, want lat=%0d stall_cycles=%0d res=%h zero=%b",
                     name, op, a, b, seen, lat, stall_cnt, bus.ALUresult, bus.zero,
                     W + 1, W + 1, exp, (exp == 0));
        end
        $display("md %s op=%0d a=%h b=%h res=%h lat=%0d", name, op, a, b, bus.ALUresult, lat);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.is_muldiv = 1'b0;
    endtask

    // Count cycles with out_valid or stall while nothing is presented
    task automatic expect_quiet(input int cycles, input string name);
        int bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: got %0d cycles with valid/stall active, want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_op   = ALU_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got stall=%b valid=%b, want 0 0", bus.stall, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got stall=%b valid=%b, want 0 0", bus.stall, bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forwarding();
        drive_idle();
        bus.in_valid       = 1'b1;
        bus.alu_op         = ALU_ADD;
        bus.forwardA       = 2'b10;
        bus.fd_ex_mem_data = 32'd5;
        bus.regReadData1   = 32'd99;
        bus.regReadData2   = 32'd7;
        bus.forwardB       = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.ALUresult !== 32'd12 || bus.out_valid !== 1'b1 || bus.stall !== 1'b0 || bus.data2 !== 32'd7) begin
            errors++;
            $display("FAIL fwd_add: got res=%h valid=%b stall=%b data2=%h, want 0000000c 1 0 00000007",
                     bus.ALUresult, bus.out_valid, bus.stall, bus.data2);
        end
        $display("alu fwd_add res=%h", bus.ALUresult);
        @(posedge clk); #1;
        bus.forwardA     = 2'b11;
        bus.regReadData2 = 32'd0;
        @(negedge clk);
        checks++;
        if (bus.ALUresult !== 32'hDEADBEEF || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL poison_a: got res=%h zero=%b, want deadbeef 0", bus.ALUresult, bus.zero);
        end
        $display("alu poison_a res=%h", bus.ALUresult);
        @(posedge clk); #1;
        bus.forwardA     = 2'b00;
        bus.regReadData1 = 32'd0;
        bus.forwardB     = 2'b11;
        bus.ALUSrc       = 1'b1;
        bus.imm          = 32'd0;
        @(negedge clk);
        checks++;
        if (bus.ALUresult !== 32'd0 || bus.zero !== 1'b1 || bus.data2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL poison_b_imm: got res=%h zero=%b data2=%h, want 00000000 1 deadbeef",
                     bus.ALUresult, bus.zero, bus.data2);
        end
        $display("alu poison_b_imm data2=%h", bus.data2);
        @(posedge clk); #1;
        bus.ALUSrc = 1'b0;
        bus.alu_op = ALU_OR;
        @(negedge clk);
        checks++;
        if (bus.ALUresult !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL poison_b_reg: got res=%h, want deadbeef", bus.ALUresult);
        end
        $display("alu poison_b_reg res=%h", bus.ALUresult);
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op = 4'($urandom_range(0, 10));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            if (i % 5 == 1) b = a;
            if (i % 5 == 2) b = 32'($urandom_range(0, 40));
            run_alu(op, a, b, bit'($urandom_range(0, 1)), "alu_rand");
        end
    endtask

    task automatic test_muldiv_directed();
        run_md(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
        run_md(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        run_md(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        run_md(MD_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1");
        run_md(MD_MUL,    32'h00000000, 32'h00012345, 32'h00000000, "mul_zero");
        run_md(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_md(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
        run_md(MD_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, "divu_by0");
        run_md(MD_REMU,   32'd100,      32'd0,        32'd100,      "remu_by0");
        run_md(MD_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_by0");
        run_md(MD_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_neg_by0");
        run_md(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
        run_md(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
    endtask

    task automatic test_muldiv_random();
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            case (i % 6)
                1: b = 32'd0;
                2: b = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(1, 300));
                4: a = 32'h80000000;
                default: ;
            endcase
            run_md(op, a, b, ref_md(op, a, b), "md_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        run_md(MD_MUL, a, b, ref_md(MD_MUL, a, b), "b2b_mul");
        run_alu(ALU_SUB, a, b, 1'b0, "b2b_sub");
        run_md(MD_DIV, a, b, ref_md(MD_DIV, a, b), "b2b_div");
        run_md(MD_REMU, b, a, ref_md(MD_REMU, b, a), "b2b_remu");
    endtask

    task automatic test_flush_busy();
        logic [31:0] fb;
        int          busy_bad = 0;
        set_operands(32'd1000, 32'd7, 1'b0, fb);
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.md_op     = MD_DIV;
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 10) bus.flush = 1'b1;
            @(negedge clk);
            if (k < 10 && (bus.stall !== 1'b1 || bus.out_valid !== 1'b0)) busy_bad++;
        end
        checks++;
        if (busy_bad != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got %0d bad busy cycles, valid=%b on flush, want 0 and 0", busy_bad, bus.out_valid);
        end
        @(posedge clk); #1;
        drive_idle();
        $display("flush busy cycle 10");
        expect_quiet(40, "flush_busy_quiet");
        run_alu(ALU_ADD, $urandom, $urandom, 1'b0, "after_flush_add");
    endtask

    task automatic test_flush_done();
        logic [31:0] fb;
        set_operands(32'd12, 32'd13, 1'b0, fb);
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.md_op     = MD_MUL;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: got valid=%b stall=%b, want 0 0", bus.out_valid, bus.stall);
        end
        @(posedge clk); #1;
        drive_idle();
        $display("flush done cycle");
        expect_quiet(10, "flush_done_quiet");
        run_md(MD_MULHU, 32'h12345678, 32'h9ABCDEF0, ref_md(MD_MULHU, 32'h12345678, 32'h9ABCDEF0), "after_flush_mulhu");
    endtask

    task automatic test_flush_idle();
        logic [31:0] fb;
        set_operands(32'd50, 32'd3, 1'b0, fb);
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.md_op     = MD_DIVU;
        bus.flush     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_md: got stall=%b valid=%b, want 0 0", bus.stall, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.is_muldiv = 1'b0;
        bus.alu_op    = ALU_ADD;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_alu: got valid=%b, want 0", bus.out_valid);
        end
        @(posedge clk); #1;
        drive_idle();
        $display("flush idle");
        expect_quiet(40, "flush_idle_quiet");
    endtask

    task automatic test_reset_mid();
        logic [31:0] fb;
        set_operands(32'hFFFF0000, 32'd3, 1'b0, fb);
        bus.in_valid  = 1'b1;
        bus.is_muldiv = 1'b1;
        bus.md_op     = MD_DIV;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got stall=%b valid=%b, want 0 0", bus.stall, bus.out_valid);
        end
        repeat (2) @(posedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset mid div");
        expect_quiet(40, "reset_mid_quiet");
        run_alu(ALU_XOR, $urandom, $urandom, 1'b0, "after_reset_xor");
        run_md(MD_DIV, 32'hFFFF0000, 32'd3, ref_md(MD_DIV, 32'hFFFF0000, 32'd3), "after_reset_div");
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_alu_random();
        test_muldiv_directed();
        test_muldiv_random();
        test_back_to_back();
        test_flush_busy();
        test_flush_done();
        test_flush_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, datapath width W in bits.
REQ-002 SHALL have parameter FWD_POISON, default 32'hDEADBEEF, value driven for an illegal forward select.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  instruction present in EX this cycle.
REQ-006 SHALL have port flush  input  1  kill current instruction, including an in-flight mul/div.
REQ-007 SHALL have port is_muldiv  input  1  instruction is RV32M (opcode 0110011, funct7 0000001).
REQ-008 SHALL have port md_op  input  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 SHALL have port alu_op  input  4  pre-decoded ALU operation code (package enum).
REQ-010 SHALL have port ALUSrc  input  1  use imm in place of operand B.
REQ-011 SHALL have ports regReadData1, regReadData2, imm  input  W each  register-file operands and immediate.
REQ-012 SHALL have ports fd_ex_mem_data, fd_mem_wb_data  input  W each  forwarded values.
REQ-013 SHALL have ports forwardA, forwardB  input  2 each  00 register, 10 EX/MEM, 01 MEM/WB, 11 illegal.
REQ-014 SHALL have port stall  output  1  freeze IF/ID/EX; high while a mul/div is outstanding.
REQ-015 SHALL have port out_valid  output  1  ALUresult valid for EX/MEM this cycle.
REQ-016 SHALL have ports ALUresult, data2  output  W each  result; store data (forwarded B, pre-imm mux).
REQ-017 SHALL have port zero  output  1  ALUresult == 0.

Function
REQ-018 SHALL resolve each operand through its forward mux; illegal select SHALL yield FWD_POISON.
REQ-019 SHALL execute non-muldiv ops combinationally: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, ZERO; out_valid = in_valid & ~flush in the same cycle; shift amount = B[log2(W)-1:0].
REQ-020 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE for mul/div.
REQ-021 SHALL, in IDLE with in_valid & is_muldiv & ~flush, latch operand magnitudes, sign-fix flags and md_op, load count = W, go to BUSY; stall SHALL assert combinationally that same cycle.
REQ-022 SHALL perform one radix-2 shift-add (mul) or restoring-subtract (div) step per BUSY cycle, decrementing count; at count 1 go to DONE.
REQ-023 SHALL, in DONE, drive the sign-corrected registered result, out_valid = 1, stall = 0, return to IDLE; result at cycle W+1 after acceptance.
REQ-024 SHALL return the 2W-bit product low half for MUL and high half for MULH/MULHSU/MULHU with RISC-V signedness.
REQ-025 SHALL, for divide by zero, produce quotient all-ones and remainder = dividend, full latency.
REQ-026 SHALL, for signed overflow (-2^(W-1) / -1), produce quotient = dividend, remainder 0.
REQ-027 SHALL, on flush in BUSY or DONE, return to IDLE next edge with no out_valid and stall low.
REQ-028 SHALL ignore in_valid while BUSY (upstream held by stall).
REQ-029 SHALL drive zero from the value actually on ALUresult, including DONE.
REQ-030 SHALL drive out_valid low in IDLE when a mul/div is being accepted.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state IDLE, count 0, result register 0, stall 0, out_valid 0.
REQ-032 SHALL abandon an in-flight operation on reset with no output; release resumes in IDLE.

Structure
REQ-033 SHALL place the alu_op enum, md_op encodings and FSM state encoding in shared package ex_pkg.
REQ-034 SHALL isolate the iterative datapath in one sub-module muldiv_iter (start, op, a, b -> done, result).
REQ-035 SHALL keep combinational ALU and forwarding in the top module.

Verification
REQ-036 SHALL cover ADD, forwardA=10, fd_ex_mem_data=5, regReadData2=7 -> ALUresult 12, out_valid same cycle, stall 0.
REQ-037 SHALL cover MULH a=32'hFFFFFFFF b=32'hFFFFFFFF -> 0 after 33 cycles; MULHU same operands -> 32'hFFFFFFFE.
REQ-038 SHALL cover DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000; REM same -> 0.
REQ-039 SHALL cover DIVU 100 / 0 -> 32'hFFFFFFFF; REMU 100 / 0 -> 100; stall high exactly 33 cycles.
REQ-040 SHALL cover flush in BUSY cycle 10 -> IDLE next cycle, no out_valid; next ADD completes normally.
REQ-041 SHALL cover rst_n low mid-DIV -> stall and out_valid 0 immediately, IDLE after release.
